prim_device: RTL and testbench

- Minimal programmable compute device with a built-in program.
- Fixed 16-entry instruction ROM, 8x32 register file, small ALU (add, sub, multiply) and a one-instruction-per-cycle sequencer.
- The built-in program computes the factorial of the switch value SW_i and presents it on HEX_o, then raises done_o.
- Used as a standalone lab block ahead of the full risc_v core.

---
 rtl/prim_device_pkg.sv | 65 ++++++
 rtl/prim_device_alu.sv | 22 ++
 rtl/prim_device.sv | 122 ++++++++++++
 tb/tb_prim_device.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/prim_device_pkg.sv
// Shared types, instruction field layout and the built-in factorial program.
package prim_device_pkg;

    localparam int unsigned ROM_DEPTH = 16;
    localparam int unsigned NREGS     = 8;
    localparam int unsigned XLEN      = 32;

    // Instruction field bit positions
    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 29;
    localparam int unsigned RD_HI  = 28;
    localparam int unsigned RD_LO  = 26;
    localparam int unsigned RS1_HI = 25;
    localparam int unsigned RS1_LO = 23;
    localparam int unsigned RS2_HI = 22;
    localparam int unsigned RS2_LO = 20;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_LI   = 3'b011,
        OP_LSW  = 3'b100,
        OP_BEQ  = 3'b101,
        OP_HALT = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [XLEN-1:0] enc(op_e op, logic [2:0] rd, logic [2:0] rs1,
                                            logic [2:0] rs2, logic [15:0] imm);
        logic [XLEN-1:0] w;
        w                = '0;
        w[OP_HI:OP_LO]   = op;
        w[RD_HI:RD_LO]   = rd;
        w[RS1_HI:RS1_LO] = rs1;
        w[RS2_HI:RS2_LO] = rs2;
        w[IMM_HI:IMM_LO] = imm;
        return w;
    endfunction

    // r1 = acc, r2 = N counting down, r3 = constant 1
    function automatic logic [XLEN-1:0] rom_word(logic [3:0] addr);
        logic [XLEN-1:0] w;
        case (addr)
            4'd0:    w = enc(OP_LI,   3'd1, 3'd0, 3'd0, 16'd1);
            4'd1:    w = enc(OP_LSW,  3'd2, 3'd0, 3'd0, 16'd0);
            4'd2:    w = enc(OP_LI,   3'd3, 3'd0, 3'd0, 16'd1);
            4'd3:    w = enc(OP_BEQ,  3'd0, 3'd2, 3'd0, 16'd7);
            4'd4:    w = enc(OP_MUL,  3'd1, 3'd1, 3'd2, 16'd0);
            4'd5:    w = enc(OP_SUB,  3'd2, 3'd2, 3'd3, 16'd0);
            4'd6:    w = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 16'd3);
            default: w = enc(OP_HALT, 3'd0, 3'd1, 3'd0, 16'd0);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/prim_device_alu.sv
// Combinational ALU: ADD / SUB / MUL, all wrapping modulo 2^32.
module prim_device_alu
    import prim_device_pkg::*;
(
    input  op_e              op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic [XLEN-1:0]  y_o
);

    // Select the arithmetic result; non-ALU ops yield zero
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_MUL:  y_o = a_i * b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/prim_device.sv
// Tiny programmable device: ROM-resident factorial program, 8x32 register file,
// one instruction per cycle, result presented on HEX_o with a sticky done_o.
module prim_device
    import prim_device_pkg::*;
#(
    parameter int unsigned SW_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [SW_W-1:0] SW_i,
    output logic [31:0]     HEX_o,
    output logic            done_o
);

    state_e          state_q, state_d;
    logic [3:0]      pc_q, pc_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] hex_q, hex_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] instr;
    op_e             op;
    logic [2:0]      rd, rs1, rs2;
    logic [15:0]     imm;
    logic [XLEN-1:0] rs1_val, rs2_val, alu_y;
    logic            unused_instr_bits;

    // Decode the current ROM word
    always_comb begin
        instr   = rom_word(pc_q);
        op      = op_e'(instr[OP_HI:OP_LO]);
        rd      = instr[RD_HI:RD_LO];
        rs1     = instr[RS1_HI:RS1_LO];
        rs2     = instr[RS2_HI:RS2_LO];
        imm     = instr[IMM_HI:IMM_LO];
        // r0 is hardwired to zero on read
        rs1_val = (rs1 == 3'd0) ? '0 : regs_q[rs1];
        rs2_val = (rs2 == 3'd0) ? '0 : regs_q[rs2];
    end

    assign unused_instr_bits = ^instr[19:16];

    prim_device_alu u_alu (
        .op_i (op),
        .a_i  (rs1_val),
        .b_i  (rs2_val),
        .y_o  (alu_y)
    );

    // Sequencer: next state, PC, register writeback and result capture
    always_comb begin
        logic            wr_en;
        logic [XLEN-1:0] wr_data;
        state_d = state_q;
        pc_d    = pc_q;
        regs_d  = regs_q;
        hex_d   = hex_q;
        done_d  = done_q;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    pc_d    = 4'd0;
                end
            end
            RUN: begin
                pc_d = pc_q + 4'd1;
                case (op)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        wr_en   = 1'b1;
                        wr_data = alu_y;
                    end
                    OP_LI: begin
                        wr_en   = 1'b1;
                        wr_data = {16'd0, imm};
                    end
                    OP_LSW: begin
                        wr_en   = 1'b1;
                        wr_data = XLEN'(SW_i);
                    end
                    OP_BEQ: begin
                        if (rs1_val == rs2_val) pc_d = imm[3:0];
                    end
                    OP_HALT: begin
                        hex_d   = rs1_val;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                    default: ;
                endcase
            end
            DONE:    ;
            default: state_d = IDLE;
        endcase
        if (wr_en && rd != 3'd0) regs_d[rd] = wr_data;
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= 4'd0;
            hex_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign HEX_o  = hex_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_prim_device.sv
// Bench for prim_device: directed and random factorial runs against a plain
// arithmetic model of N! and the 5+4N edge latency.
module tb_prim_device;

    localparam int unsigned SW_W = 3;

    logic            clk;
    logic            rst;
    logic            en;
    logic [SW_W-1:0] sw;
    logic [31:0]     hex;
    logic            done;

    int checks;
    int failures;

    prim_device #(.SW_W(SW_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .SW_i   (sw),
        .HEX_o  (hex),
        .done_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Start a run of N, wait for done, check latency/result, then poke en in DONE
    task automatic run_check(input int n, input bit hold_en, input bit scramble);
        int          lat;
        bit          seen;
        bit          early;
        logic [31:0] res;
        sw = SW_W'(n);
        en = 1'b1;
        tick();                     // E0
        if (!hold_en) en = 1'b0;
        seen  = 1'b0;
        early = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            // N is captured at E0+2, so the switches may move afterwards
            if (scramble && k >= 3) sw = SW_W'($urandom);
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end else if (hex !== 32'd0) begin
                early = 1'b1;
            end
        end
        check($sformatf("seen_n%0d", n), 32'(seen), 32'd1);
        check($sformatf("latency_n%0d", n), 32'(lat), 32'(5 + 4 * n));
        check($sformatf("hex_n%0d", n), hex, fact(n));
        check($sformatf("hex_quiet_n%0d", n), 32'(early), 32'd0);
        res = hex;
        sw  = SW_W'($urandom);
        en  = 1'b1;
        tick();
        en  = 1'b0;
        tick();
        tick();
        check($sformatf("done_hold_n%0d", n), 32'(done), 32'd1);
        check($sformatf("hex_hold_n%0d", n), hex, res);
        en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        sw       = '0;

        do_reset();
        check("reset_hex", hex, 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Idle without en must not start
        for (int i = 0; i < 40; i++) tick();
        check("idle_done", 32'(done), 32'd0);

        run_check(7, 1'b1, 1'b0);
        do_reset();
        run_check(0, 1'b1, 1'b0);
        do_reset();
        run_check(1, 1'b0, 1'b0);
        do_reset();
        run_check(3, 1'b1, 1'b0);
        do_reset();
        run_check(5, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            run_check(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        end

        // Reset mid-run aborts and leaves the device idle
        do_reset();
        sw = 3'd6;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        check("midrun_hex", hex, 32'd0);
        check("midrun_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("midrun_idle_done", 32'(done), 32'd0);
        check("midrun_idle_hex", hex, 32'd0);
        run_check(4, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
